// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60) and counter width helpers.
package vga_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;

  // Raw per-tick timing flags carried through the alignment pipeline.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } vga_raw_t;

  // Bits needed to hold the value n itself, so a compare against a segment
  // end equal to the total never truncates.
  function automatic int unsigned bits_for(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Tick-enabled shift register used to align timing flags with read data.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign o_q = i_d;
    end else begin : g_pipe
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Shift one stage per enable; reset flushes every stage to zero.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          for (int unsigned i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else if (i_en) begin
          r_stage[0] <= i_d;
          for (int unsigned i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator with framebuffer read addressing and aligned colour output.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned ADDR_W   = 19,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              video_en,
  input  logic [DATA_W-1:0] pix_data,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_rd_en,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [DATA_W-1:0] rgb_out,
  output logic              frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = bits_for(CLK_DIV - 1);
  localparam int unsigned HW      = bits_for(H_TOTAL);
  localparam int unsigned VW      = bits_for(V_TOTAL);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [HW-1:0]    H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]    H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]    H_SS     = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]    H_SE     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]    V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]    V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]    V_SS     = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]    V_SE     = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0]  r_div;
  logic [HW-1:0]     r_h;
  logic [VW-1:0]     r_v;
  logic [ADDR_W-1:0] r_addr;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_de;
  logic [DATA_W-1:0] r_rgb;

  logic              w_tick;
  logic              w_h_last;
  logic              w_v_last;
  vga_raw_t          w_raw;
  vga_raw_t          w_dly;

  // Gated by rst_n so no strobe escapes while reset is held (CLK_DIV=1 case).
  assign w_tick   = rst_n && (r_div == DIV_LAST);
  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);

  assign w_raw.hs  = (r_h >= H_SS) && (r_h < H_SE);
  assign w_raw.vs  = (r_v >= V_SS) && (r_v < V_SE);
  assign w_raw.act = (r_h < H_ACT) && (r_v < V_ACT);

  assign pix_rd_en   = w_tick && w_raw.act;
  assign frame_start = w_tick && (r_h == '0) && (r_v == '0);
  assign pix_addr    = r_addr;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign de          = r_de;
  assign rgb_out     = r_rgb;

  // Pixel tick divider: counts 0..CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (!rst_n)               r_div <= '0;
    else if (r_div == DIV_LAST) r_div <= '0;
    else                      r_div <= r_div + DIV_W'(1);
  end

  // Horizontal and vertical position counters, advanced per tick.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (w_h_last) begin
        r_h <= '0;
        r_v <= w_v_last ? '0 : r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
    end
  end

  // Incremental framebuffer address: +1 per read, cleared on the last tick of a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (w_tick) begin
      if (w_h_last && w_v_last) r_addr <= '0;
      else if (w_raw.act)       r_addr <= r_addr + ADDR_W'(1);
    end
  end

  // RD_LAT stages here plus the output register below give RD_LAT+1 ticks total.
  vga_delay_line #(
    .WIDTH ($bits(vga_raw_t)),
    .DEPTH (RD_LAT)
  ) u_align (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (w_tick),
    .i_d     (w_raw),
    .o_q     (w_dly)
  );

  // Output register: syncs at configured polarity, colour blanked outside active or when disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hsync <= ~HS_POL;
      r_vsync <= ~VS_POL;
      r_de    <= 1'b0;
      r_rgb   <= '0;
    end else if (w_tick) begin
      r_hsync <= w_dly.hs ? HS_POL : ~HS_POL;
      r_vsync <= w_dly.vs ? VS_POL : ~VS_POL;
      r_de    <= w_dly.act;
      r_rgb   <= (w_dly.act && video_en) ? pix_data : '0;
    end
  end

endmodule
